lsb_queue: RTL
==============

# lsb_queue

Parametrised in-order load/store buffer between the dispatch stage, the reservation stations, the reorder buffer (ROB) and the memory controller. Entries are allocated in program order at dispatch, receive address/data later from the RS, and are issued to memory strictly from the head. Load results go to the common data bus (CDB) with their ROB tag. Stores are written only after ROB commit. Occupancy is tracked by an explicit counter, so full and empty are unambiguous at any depth.

## Interface
- DEPTH, 16, entry count; power of two, ≥2
- TAG_W, 4, ROB tag width
- XLEN, 32, address/data width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low freezes all state and outputs
- alloc_valid  in  1  dispatch allocates one entry
- alloc_op  in  4  bit3 store, bit2 unsigned, [1:0] size (00 B, 01 H, 10 W)
- alloc_tag  in  TAG_W  ROB tag of the instruction
- alloc_ready  out  1  entry available (count < DEPTH)
- alloc_idx  out  log2(DEPTH)  index the next allocation receives (= tail)
- fill_valid  in  1  RS supplies operands
- fill_idx  in  log2(DEPTH)  target entry
- fill_addr  in  XLEN  effective address
- fill_data  in  XLEN  store data (ignored for loads)
- commit_valid  in  1  ROB commits a store
- commit_tag  in  TAG_W  tag of the committed store
- flush  in  1  mispredict squash
- mem_req  out  1  memory request, level-held
- mem_we  out  1  1 = write
- mem_addr  out  XLEN  request address
- mem_wdata  out  XLEN  store data, low bytes per size
- mem_size  out  2  alloc_op[1:0] of the head entry
- mem_done  in  1  one-cycle completion pulse
- mem_rdata  in  XLEN  raw read data, aligned to bit 0
- cdb_valid  out  1  load result valid, one cycle
- cdb_tag  out  TAG_W  ROB tag of the result
- cdb_value  out  XLEN  extended load value

## Operation
- Entry state: busy, filled, committed, op, tag, addr, data. head, tail and count are registers. Pointers wrap modulo DEPTH.
- Allocate: when alloc_valid && alloc_ready, write entry[tail] (filled=0, committed=0), then tail+1 and count+1. If the queue is full, alloc_valid is ignored and no state changes.
- Fill: sets addr, data and filled=1 on entry[fill_idx]. A fill to a non-busy entry is ignored.
- Commit: sets committed=1 on the oldest busy uncommitted store whose tag equals commit_tag. A commit that matches no such store is ignored.
- FSM IDLE → MEM:
  - Enter MEM when the head is busy && filled and either the head is a load, or the head is a store with committed=1.
  - In MEM, mem_req=1 and address, data, size and we are latched from the head.
  - On mem_done, return to IDLE and retire the head: busy=0, head+1, count-1.
  - A load that retires drives the CDB next cycle.
- Load extension: for B/H, sign-extend when bit2=0 and zero-extend when bit2=1. For W, pass mem_rdata through.
- Stores never drive the CDB.
- Simultaneous allocate and retire in one cycle: count is unchanged and both pointers advance.
- Allocate when count==DEPTH-1 and a retire happens in the same cycle: the allocation is accepted. alloc_ready is computed from the registered count, so this case is reached only when alloc_ready was already 1.

## Timing
- Reset values:
  - Outputs: all 0 except alloc_ready=1.
  - head=tail=count=0, every busy=0, FSM=IDLE.
- A reset asserted mid-request drops mem_req next cycle. A subsequent mem_done is ignored.
- Allocation is visible in alloc_idx/alloc_ready the next cycle.
- A fill issued in the same cycle as the entry's allocation is ignored.
- A fill of the head in cycle N gives mem_req=1 in cycle N+1 if the FSM is IDLE.
- mem_done in cycle M gives, in cycle M+1: cdb_valid=1 for a load, mem_req=0, and the updated head.
- Back-to-back issue: the next head is eligible in cycle M+1, so its mem_req rises in M+2.
- With rdy=0, all registers hold and mem_done/fill/commit/alloc inputs are ignored.

## Configuration
- LSB_FLUSH_EN defined:
  - flush=1 sets tail = head + (number of committed entries counted from the head), and count = that number.
  - All squashed entries are cleared.
  - An in-flight load completes on the memory side, but its CDB broadcast is suppressed.
  - Alloc, fill and commit arriving in the flush cycle are ignored.
- LSB_FLUSH_EN undefined: the flush port exists but is ignored. No squash logic is built.

## Test plan
- Reset, then allocate 16 loads → alloc_ready=0 after the 16th. A 17th alloc_valid leaves count=16 and tail=0.
- LB tag 3, fill addr 0x100, mem_rdata=0x000000F0 → cdb_valid one cycle, tag 3, value 0xFFFFFFF0. The same access as LBU gives 0x000000F0.
- SW tag 5, filled with data 0xDEADBEEF, no commit for 10 cycles → mem_req stays 0. Commit tag 5 → mem_req=1, mem_we=1, mem_wdata=0xDEADBEEF. No CDB output.
- Alloc and retire in the same cycle with count=DEPTH-1 → count stays DEPTH-1. Pointers wrap from 15 to 0 without loss.
- LSB_FLUSH_EN: entries are SW (committed), LW in flight, LW, LW. Flush → count=1. The in-flight LW's mem_done produces no cdb_valid, and the SW then issues.
- rdy low for 3 cycles while mem_done pulses → the pulse is ignored, mem_req stays high and no state changes.

Source files
------------

// File: rtl/lsb_queue_if.sv
// Signal bundle between the load/store buffer and its neighbours: dispatch, RS fill,
// ROB commit, flush, the memory controller and the CDB.
interface lsb_queue_if #(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32,
  parameter int IDX_W = 4
);
  logic             alloc_valid;
  logic [3:0]       alloc_op;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic             fill_valid;
  logic [IDX_W-1:0] fill_idx;
  logic [XLEN-1:0]  fill_addr;
  logic [XLEN-1:0]  fill_data;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic             flush;
  logic             mem_req;
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic [1:0]       mem_size;
  logic             mem_done;
  logic [XLEN-1:0]  mem_rdata;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;

  modport master (
    output alloc_valid, alloc_op, alloc_tag, fill_valid, fill_idx, fill_addr, fill_data,
           commit_valid, commit_tag, flush, mem_done, mem_rdata,
    input  alloc_ready, alloc_idx, mem_req, mem_we, mem_addr, mem_wdata, mem_size,
           cdb_valid, cdb_tag, cdb_value
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_tag, fill_valid, fill_idx, fill_addr, fill_data,
           commit_valid, commit_tag, flush, mem_done, mem_rdata,
    output alloc_ready, alloc_idx, mem_req, mem_we, mem_addr, mem_wdata, mem_size,
           cdb_valid, cdb_tag, cdb_value
  );
endinterface

// File: rtl/lsb_queue.sv
// In-order load/store buffer: allocate at dispatch, fill from the RS, issue only from the head.
// Optional squash support is built when LSB_FLUSH_EN is defined.
module lsb_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  lsb_queue_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {S_IDLE, S_MEM} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d, filled_q, filled_d, committed_q, committed_d;
  logic [3:0]       op_q   [DEPTH];
  logic [3:0]       op_d   [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [TAG_W-1:0] tag_d  [DEPTH];
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  addr_d [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [XLEN-1:0]  data_d [DEPTH];
  logic             mem_we_q, mem_we_d, ld_uns_q, ld_uns_d, squashed_q, squashed_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]       mem_size_q, mem_size_d;
  logic [TAG_W-1:0] ld_tag_q, ld_tag_d, cdb_tag_q, cdb_tag_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [XLEN-1:0]  cdb_value_q, cdb_value_d;

  logic             flush_act, alloc_fire, fill_ok, commit_ok, retire;
  logic             commit_hit, head_fill_now, head_commit, head_ready;
  logic [IDX_W-1:0] commit_sel;
  logic [XLEN-1:0]  head_addr, head_data;

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                   input logic [1:0] size, input logic uns);
    case (size)
      2'b00:   load_extend = {{(XLEN-8){raw[7] & ~uns}}, raw[7:0]};
      2'b01:   load_extend = {{(XLEN-16){raw[15] & ~uns}}, raw[15:0]};
      default: load_extend = raw;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [XLEN-1:0] d, input logic [1:0] size);
    case (size)
      2'b00:   store_lanes = {{(XLEN-8){1'b0}}, d[7:0]};
      2'b01:   store_lanes = {{(XLEN-16){1'b0}}, d[15:0]};
      default: store_lanes = d;
    endcase
  endfunction

`ifdef LSB_FLUSH_EN
  logic             flush_skip;
  logic [IDX_W-1:0] flush_head;
  logic [CNT_W-1:0] flush_run;

  assign flush_act = bus.flush;

  // An issued load at the head is dropped from the queue at once; its memory access still finishes.
  always_comb begin
    logic run_on;
    flush_skip = (state_q == S_MEM) && !squashed_q && (!mem_we_q || bus.mem_done);
    flush_head = head_q + IDX_W'(flush_skip);
    flush_run  = '0;
    run_on     = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (run_on && (i < DEPTH - int'(flush_skip)) &&
          busy_q[flush_head + IDX_W'(i)] && committed_q[flush_head + IDX_W'(i)])
        flush_run = flush_run + CNT_W'(1);
      else
        run_on = 1'b0;
    end
  end
`else
  logic unused_flush;
  assign flush_act    = 1'b0;
  assign unused_flush = bus.flush;
`endif

  assign alloc_fire = bus.alloc_valid && (count_q < CNT_W'(DEPTH)) && !flush_act;
  assign fill_ok    = bus.fill_valid && busy_q[bus.fill_idx] && !flush_act;
  assign commit_ok  = bus.commit_valid && !flush_act;
  assign retire     = (state_q == S_MEM) && bus.mem_done && !squashed_q;

  // Same-cycle fill or commit of the head lets it issue without waiting a cycle.
  always_comb begin
    commit_hit = 1'b0;
    commit_sel = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (!commit_hit && busy_q[head_q + IDX_W'(i)] && op_q[head_q + IDX_W'(i)][3] &&
          !committed_q[head_q + IDX_W'(i)] && (tag_q[head_q + IDX_W'(i)] == bus.commit_tag)) begin
        commit_hit = 1'b1;
        commit_sel = head_q + IDX_W'(i);
      end
    end
    head_fill_now = fill_ok && (bus.fill_idx == head_q);
    head_addr     = head_fill_now ? bus.fill_addr : addr_q[head_q];
    head_data     = head_fill_now ? bus.fill_data : data_q[head_q];
    head_commit   = committed_q[head_q] || (commit_ok && commit_hit && (commit_sel == head_q));
    head_ready    = busy_q[head_q] && (filled_q[head_q] || head_fill_now) &&
                    (!op_q[head_q][3] || head_commit);
  end

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q + CNT_W'(alloc_fire) - CNT_W'(retire);
    busy_d      = busy_q;
    filled_d    = filled_q;
    committed_d = committed_q;
    op_d        = op_q;
    tag_d       = tag_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    ld_uns_d    = ld_uns_q;
    ld_tag_d    = ld_tag_q;
    squashed_d  = squashed_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;

    case (state_q)
      S_IDLE: if (head_ready && !flush_act) begin
        state_d     = S_MEM;
        mem_we_d    = op_q[head_q][3];
        mem_addr_d  = head_addr;
        mem_wdata_d = store_lanes(head_data, op_q[head_q][1:0]);
        mem_size_d  = op_q[head_q][1:0];
        ld_uns_d    = op_q[head_q][2];
        ld_tag_d    = tag_q[head_q];
      end
      S_MEM: if (bus.mem_done) begin
        state_d    = S_IDLE;
        squashed_d = 1'b0;
        if (!squashed_q && !mem_we_q) begin
          cdb_valid_d = 1'b1;
          cdb_tag_d   = ld_tag_q;
          cdb_value_d = load_extend(bus.mem_rdata, mem_size_q, ld_uns_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + IDX_W'(1);
    end
    if (fill_ok) begin
      addr_d[bus.fill_idx]   = bus.fill_addr;
      data_d[bus.fill_idx]   = bus.fill_data;
      filled_d[bus.fill_idx] = 1'b1;
    end
    if (commit_ok && commit_hit)
      committed_d[commit_sel] = 1'b1;
    if (alloc_fire) begin
      busy_d[tail_q]      = 1'b1;
      filled_d[tail_q]    = 1'b0;
      committed_d[tail_q] = 1'b0;
      op_d[tail_q]        = bus.alloc_op;
      tag_d[tail_q]       = bus.alloc_tag;
      tail_d              = tail_q + IDX_W'(1);
    end

`ifdef LSB_FLUSH_EN
    if (bus.flush) begin
      head_d      = flush_head;
      tail_d      = flush_head + flush_run[IDX_W-1:0];
      count_d     = flush_run;
      cdb_valid_d = 1'b0;
      if (flush_skip && !bus.mem_done)
        squashed_d = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
        if ({1'b0, IDX_W'(j) - flush_head} >= flush_run) begin
          busy_d[j]      = 1'b0;
          filled_d[j]    = 1'b0;
          committed_d[j] = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      filled_q    <= '0;
      committed_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      ld_uns_q    <= 1'b0;
      ld_tag_q    <= '0;
      squashed_q  <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      filled_q    <= filled_d;
      committed_q <= committed_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      ld_uns_q    <= ld_uns_d;
      ld_tag_q    <= ld_tag_d;
      squashed_q  <= squashed_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  // Payload fields carry no meaning until busy is set, so they skip reset.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      op_q   <= op_d;
      tag_q  <= tag_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign bus.alloc_ready = count_q < CNT_W'(DEPTH);
  assign bus.alloc_idx   = tail_q;
  assign bus.mem_req     = (state_q == S_MEM);
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_size    = mem_size_q;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_tag     = cdb_tag_q;
  assign bus.cdb_value   = cdb_value_q;
endmodule
